// File: rtl/pc_unit_if.sv
// ----------------------------------------------------------------------------
// pc_unit_if : PC-update request and RAS status bundle | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              pc_write;
  logic [1:0]        pc_src;
  logic              link;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_addr;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output pc_write, pc_src, link, branch_offset, jump_target,
    input  pc, ret_addr, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  pc_write, pc_src, link, branch_offset, jump_target,
    output pc, ret_addr, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit : program counter with return-address stack | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
  parameter int              ADDR_W    = 32,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pc_unit_if.slave    bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] top_val;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic              empty;
  logic              full;
  logic              push;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(RAS_DEPTH));
  // Lower count bits wrap to 0 when full, so minus one still lands on the top slot
  assign top_idx  = cnt_q[PTR_W-1:0] - PTR_W'(1);
  assign wr_idx   = cnt_q[PTR_W-1:0];
  assign top_val  = empty ? '0 : stack_q[top_idx];
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    if (bus.pc_write) begin
      case (bus.pc_src)
        2'b00: pc_d = pc_plus4;
        2'b01: pc_d = pc_q + bus.branch_offset;
        2'b10: begin
          pc_d = bus.jump_target;
          if (bus.link) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              push  = 1'b1;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          if (empty) begin
            pc_d  = pc_plus4;
            udf_d = 1'b1;
          end else begin
            pc_d  = top_val;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (push) begin
        stack_q[wr_idx] <= pc_plus4;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ret_addr      = top_val;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_unit : directed plus random check of pc_unit against a queue model | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_unit;

  localparam int          ADDR_W    = 32;
  localparam int          RAS_DEPTH = 8;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(ADDR_W)) bus ();

  pc_unit #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: PC as a number, RAS as a LIFO queue
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_ras[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic w, input logic [1:0] s,
                       input logic l, input logic [31:0] off, input logic [31:0] tgt);
    if (!r) begin
      m_pc = RESET_PC;
      m_ras.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (w) begin
      case (s)
        2'b00: m_pc = m_pc + 32'd4;
        2'b01: m_pc = m_pc + off;
        2'b10: begin
          if (l) begin
            if (m_ras.size() == RAS_DEPTH) m_ovf = 1'b1;
            else m_ras.push_back(m_pc + 32'd4);
          end
          m_pc = tgt;
        end
        default: begin
          if (m_ras.size() == 0) begin
            m_udf = 1'b1;
            m_pc  = m_pc + 32'd4;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_ret;
    exp_ret = (m_ras.size() == 0) ? 32'h0 : m_ras[$];
    chk({tag, ".pc"},    bus.pc,            m_pc);
    chk({tag, ".ret"},   bus.ret_addr,      exp_ret);
    chk({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    chk({tag, ".full"},  32'(bus.ras_full),  32'(m_ras.size() == RAS_DEPTH));
    chk({tag, ".ovf"},   32'(bus.ras_overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.ras_underflow), 32'(m_udf));
  endtask

  task automatic step(input string tag, input logic r, input logic w, input logic [1:0] s,
                      input logic l, input logic [31:0] off, input logic [31:0] tgt);
    @(negedge clk);
    rst_n             = r;
    bus.pc_write      = w;
    bus.pc_src        = s;
    bus.link          = l;
    bus.branch_offset = off;
    bus.jump_target   = tgt;
    @(posedge clk);
    model(r, w, s, l, off, tgt);
    #1;
    compare_all(tag);
  endtask

  task automatic reset_release(input string tag);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.pc_write = 1'b0;
    #1;
    compare_all(tag);
  endtask

  logic [31:0] saved_ret;

  initial begin
    bus.pc_write = 1'b0;
    bus.pc_src = 2'b00;
    bus.link = 1'b0;
    bus.branch_offset = '0;
    bus.jump_target = '0;

    // Reset and increment
    step("rst0", 1'b0, 1'b0, 2'b00, 1'b0, 0, 0);
    step("rst1", 1'b0, 1'b0, 2'b00, 1'b0, 0, 0);
    chk("reset_pc", bus.pc, 32'h0);
    for (int i = 0; i < 3; i++) step("inc", 1'b1, 1'b1, 2'b00, 1'b0, 0, 0);
    chk("inc_pc", bus.pc, 32'hC);
    for (int i = 0; i < 5; i++) step("hold", 1'b1, 1'b0, 2'b11, 1'b1, 32'h5, 32'h77);
    chk("hold_pc", bus.pc, 32'hC);

    // Branch and wrap-around
    step("j100", 1'b1, 1'b1, 2'b10, 1'b0, 0, 32'h100);
    step("br", 1'b1, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFF0, 32'h999);
    chk("br_pc", bus.pc, 32'hF0);
    step("jmax", 1'b1, 1'b1, 2'b10, 1'b0, 0, 32'hFFFF_FFFC);
    step("wrap", 1'b1, 1'b1, 2'b00, 1'b0, 0, 0);
    chk("wrap_pc", bus.pc, 32'h0);

    // Call/return LIFO
    step("j20", 1'b1, 1'b1, 2'b10, 1'b0, 0, 32'h20);
    step("call1", 1'b1, 1'b1, 2'b10, 1'b1, 0, 32'h400);
    chk("call1_ret", bus.ret_addr, 32'h24);
    step("call2", 1'b1, 1'b1, 2'b10, 1'b1, 0, 32'h800);
    chk("call2_ret", bus.ret_addr, 32'h404);
    step("ret1", 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
    chk("ret1_pc", bus.pc, 32'h404);
    step("ret2", 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
    chk("ret2_pc", bus.pc, 32'h24);
    chk("ret2_empty", 32'(bus.ras_empty), 32'h1);

    // Overflow
    for (int i = 0; i < 8; i++) step("push", 1'b1, 1'b1, 2'b10, 1'b1, 0, 32'h1000 + 32'(i) * 32'h10);
    chk("ovf_full", 32'(bus.ras_full), 32'h1);
    saved_ret = bus.ret_addr;
    step("push9", 1'b1, 1'b1, 2'b10, 1'b1, 0, 32'h2000);
    chk("ovf_pc", bus.pc, 32'h2000);
    chk("ovf_flag", 32'(bus.ras_overflow), 32'h1);
    chk("ovf_ret", bus.ret_addr, saved_ret);

    // Underflow
    step("rstu", 1'b0, 1'b1, 2'b10, 1'b1, 0, 32'h1);
    reset_release("relu");
    step("j50", 1'b1, 1'b1, 2'b10, 1'b0, 0, 32'h50);
    step("pop_e", 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
    chk("udf_pc", bus.pc, 32'h54);
    chk("udf_flag", 32'(bus.ras_underflow), 32'h1);
    step("push_u", 1'b1, 1'b1, 2'b10, 1'b1, 0, 32'h300);
    step("pop_u", 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
    chk("udf_pop_pc", bus.pc, 32'h58);
    chk("udf_sticky", 32'(bus.ras_underflow), 32'h1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step("mpush", 1'b1, 1'b1, 2'b10, 1'b1, 0, 32'h600 + 32'(i) * 32'h8);
    step("mrst", 1'b0, 1'b1, 2'b10, 1'b1, 0, 32'hABC);
    chk("mrst_pc", bus.pc, RESET_PC);
    chk("mrst_empty", 32'(bus.ras_empty), 32'h1);
    reset_release("mrel");
    chk("mrel_pc", bus.pc, RESET_PC);

    // Randomized traffic, weighted toward calls/returns so both stack limits recur
    for (int i = 0; i < 400; i++) begin
      logic        r, w, l;
      logic [1:0]  s;
      int          sel;
      r   = ($urandom_range(0, 49) != 0);
      w   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      s   = (sel < 2) ? 2'b00 : (sel < 3) ? 2'b01 : (sel < 6) ? 2'b10 : 2'b11;
      l   = ($urandom_range(0, 3) != 0);
      step("rnd", r, w, s, l, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
